xfer_ctrl: RTL and testbench
============================

XFER_CTRL -- requirements
Module: xfer_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, giving the serial bits per word (shift pulses per word).
REQ-002 SHALL have parameter TIMEOUT, default 255, range 1..255, giving the maximum cycles spent in any wait state.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to transfer the 4-word TX RAM.
REQ-006 SHALL have port Rx_ready, input, 1 bit: receiver idle and able to accept a word.
REQ-007 SHALL have port Rx_finish, input, 1 bit: receiver has stored all 4 words.
REQ-008 SHALL have port Tx_vld, output, 1 bit: a TX word is valid and offered to the receiver.
REQ-009 SHALL have port rd, output, 1 bit: TX RAM read enable.
REQ-010 SHALL have port rd_adr, output, 2 bits: TX RAM word address.
REQ-011 SHALL have port load, output, 1 bit: capture RAM read data into the TX shift register.
REQ-012 SHALL have port shift, output, 1 bit: shift the TX shift register by one bit.
REQ-013 SHALL have ports busy, done and err, outputs, 1 bit each: transfer in progress; one-cycle completion pulse; timeout error, held.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, READ, LOAD, OFFER, SHIFT, NEXT, WAIT_FIN, DONE, ERR; outputs SHALL be decoded from the state (and, for rd_adr, a register) only.
REQ-015 IDLE: all outputs 0; start=1 -> READ; rd_adr SHALL be 0 on leaving IDLE.
REQ-016 READ: rd=1 for exactly one cycle -> LOAD; the RAM is synchronous, so its data is valid during LOAD.
REQ-017 LOAD: load=1 for exactly one cycle -> OFFER.
REQ-018 OFFER: Tx_vld=1; Rx_ready=1 sampled -> SHIFT next cycle; if Rx_ready is already 1 on entry, SHIFT SHALL follow after one OFFER cycle.
REQ-019 SHIFT: shift=1 for exactly BITS consecutive cycles (bit counter 0..BITS-1), then -> NEXT; Tx_vld SHALL be 0 in SHIFT.
REQ-020 NEXT: rd_adr==3 -> WAIT_FIN; otherwise rd_adr increments by 1 -> READ.
REQ-021 WAIT_FIN: Rx_finish=1 -> DONE.
REQ-022 DONE: done=1 for exactly one cycle -> IDLE.
REQ-023 Timeout: a cycle counter SHALL clear on entry to OFFER and to WAIT_FIN; if the awaited input is still 0 in the TIMEOUT-th cycle of the state, the next state SHALL be ERR.
REQ-024 ERR: err=1 and all other outputs 0; start=0 -> IDLE; err SHALL remain 1 while start=1.
REQ-025 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-026 start SHALL be ignored outside IDLE and ERR; a start held at 1 through DONE SHALL begin a new transfer from IDLE.
REQ-027 rd_adr SHALL hold its value in every state except NEXT (increment) and IDLE (forced to 0); it SHALL never wrap during a transfer.
REQ-028 A full error-free transfer with Rx_ready immediately available SHALL take 4*(3+BITS+1) cycles from leaving IDLE to WAIT_FIN.

Reset
REQ-029 clr=0 at a clock edge SHALL force IDLE, rd_adr=0, bit and timeout counters=0, and all outputs 0 on the next cycle, including mid-transfer.
REQ-030 No output SHALL glitch high on the first cycle after clr returns to 1.

Structure
REQ-031 The state encoding and the default values of BITS and TIMEOUT SHALL live in the shared package xfer_pkg.
REQ-032 The timeout counter SHALL be a sub-module xfer_timer with ports clk, clr, restart, expired; the bit counter SHALL stay inline.

Verification
REQ-033 Scenario: start=1 with Rx_ready held at 1 -> rd pulses with rd_adr=0,1,2,3; 8 shift pulses per word; done pulses 1 cycle after Rx_finish; rd_adr=3 at done.
REQ-034 Scenario: Rx_ready held 0 for 5 cycles per word -> Tx_vld high exactly 6 cycles per word; no err.
REQ-035 Scenario: Rx_ready never rises with TIMEOUT=255 -> ERR entered 255 cycles after OFFER entry; err=1 until start=0, then IDLE.
REQ-036 Scenario: Rx_finish withheld after word 3 -> err=1 after TIMEOUT cycles in WAIT_FIN; done never pulses.
REQ-037 Scenario: clr=0 during SHIFT of word 2 -> next cycle all outputs 0, rd_adr=0; a later start restarts at word 0.
REQ-038 Scenario: start toggled during SHIFT -> no effect on the sequence; start held high through DONE -> a second transfer begins immediately.

Source files
------------

// File: rtl/xfer_pkg.sv
// Shared definitions for the TX word transfer controller: state encoding and
// default word width / wait-state timeout.
package xfer_pkg;

   localparam int unsigned BITS_DEF    = 8;
   localparam int unsigned TIMEOUT_DEF = 255;

   localparam logic [1:0] LAST_ADR = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_OFFER,
      S_SHIFT,
      S_NEXT,
      S_WAIT_FIN,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/xfer_timer.sv
// Wait-state cycle counter: cleared by restart, expired in the TIMEOUT-th
// cycle after the restart edge; saturates so it can never wrap back to expiry.
module xfer_timer #(
   parameter int unsigned TIMEOUT = xfer_pkg::TIMEOUT_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic restart,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!clr) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/xfer_ctrl.sv
// Moves the 4-word TX RAM to the receiver: read, load, offer, shift BITS bits
// per word, then wait for the receiver to report completion.
module xfer_ctrl #(
   parameter int unsigned BITS    = xfer_pkg::BITS_DEF,
   parameter int unsigned TIMEOUT = xfer_pkg::TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic       Rx_ready,
   input  logic       Rx_finish,
   output logic       Tx_vld,
   output logic       rd,
   output logic [1:0] rd_adr,
   output logic       load,
   output logic       shift,
   output logic       busy,
   output logic       done,
   output logic       err
);

   import xfer_pkg::*;

   localparam int unsigned BW = (BITS > 1) ? $clog2(BITS) : 1;

   state_t          state;
   state_t          nxt;
   logic [BW-1:0]   bcnt;
   logic            last_bit;
   logic            restart;
   logic            expired;

   assign last_bit = (bcnt == BW'(BITS - 1));

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     if (start) nxt = S_READ;
         S_READ:     nxt = S_LOAD;
         S_LOAD:     nxt = S_OFFER;
         S_OFFER: begin
            if (Rx_ready)     nxt = S_SHIFT;
            else if (expired) nxt = S_ERR;
         end
         S_SHIFT:    if (last_bit) nxt = S_NEXT;
         S_NEXT:     nxt = (rd_adr == LAST_ADR) ? S_WAIT_FIN : S_READ;
         S_WAIT_FIN: begin
            if (Rx_finish)    nxt = S_DONE;
            else if (expired) nxt = S_ERR;
         end
         S_DONE:     nxt = S_IDLE;
         S_ERR:      if (!start) nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
   end

   // The timer restarts on the edge that enters a wait state, so its count is
   // zero during the first cycle spent there.
   assign restart = ((nxt == S_OFFER)    && (state != S_OFFER)) ||
                    ((nxt == S_WAIT_FIN) && (state != S_WAIT_FIN));

   xfer_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .clr     (clr),
      .restart (restart),
      .expired (expired)
   );

   // Outputs are registered from the next state so they line up exactly with
   // the state register and never depend combinationally on inputs.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state  <= S_IDLE;
         bcnt   <= '0;
         rd_adr <= '0;
         Tx_vld <= 1'b0;
         rd     <= 1'b0;
         load   <= 1'b0;
         shift  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= nxt;

         if ((state == S_SHIFT) && !last_bit) bcnt <= bcnt + BW'(1);
         else                                 bcnt <= '0;

         if (nxt == S_IDLE)                          rd_adr <= '0;
         else if ((state == S_NEXT) && (nxt == S_READ)) rd_adr <= rd_adr + 2'd1;

         Tx_vld <= (nxt == S_OFFER);
         rd     <= (nxt == S_READ);
         load   <= (nxt == S_LOAD);
         shift  <= (nxt == S_SHIFT);
         busy   <= !((nxt == S_IDLE) || (nxt == S_DONE) || (nxt == S_ERR));
         done   <= (nxt == S_DONE);
         err    <= (nxt == S_ERR);
      end
   end

endmodule

// File: tb/tb_xfer_ctrl.sv
// Bench for xfer_ctrl: a cycle table on a small instance (BITS=2, TIMEOUT=3)
// plus directed sequences on a default-sized instance.
module tb_xfer_ctrl;

   typedef enum int {ST_IDLE, ST_READ, ST_LOAD, ST_OFFER, ST_SHIFT, ST_NEXT,
                     ST_WAIT, ST_DONE, ST_ERR} st_e;

   typedef struct {
      logic       clr;
      logic       start;
      logic       rdy;
      logic       fin;
      st_e        st;
      logic [1:0] adr;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // small instance
   logic s_clr = 1'b0, s_start = 1'b0, s_rdy = 1'b0, s_fin = 1'b0;
   logic s_tx, s_rd, s_load, s_shift, s_busy, s_done, s_err;
   logic [1:0] s_adr;
   logic [6:0] s_obs;
   assign s_obs = {s_tx, s_rd, s_load, s_shift, s_busy, s_done, s_err};

   xfer_ctrl #(.BITS(2), .TIMEOUT(3)) u_small (
      .clk(clk), .clr(s_clr), .start(s_start), .Rx_ready(s_rdy), .Rx_finish(s_fin),
      .Tx_vld(s_tx), .rd(s_rd), .rd_adr(s_adr), .load(s_load), .shift(s_shift),
      .busy(s_busy), .done(s_done), .err(s_err));

   // default-sized instance
   logic b_clr = 1'b0, b_start = 1'b0, b_rdy = 1'b0, b_fin = 1'b0;
   logic b_tx, b_rd, b_load, b_shift, b_busy, b_done, b_err;
   logic [1:0] b_adr;
   logic [6:0] b_obs;
   assign b_obs = {b_tx, b_rd, b_load, b_shift, b_busy, b_done, b_err};

   xfer_ctrl #(.BITS(8), .TIMEOUT(255)) u_big (
      .clk(clk), .clr(b_clr), .start(b_start), .Rx_ready(b_rdy), .Rx_finish(b_fin),
      .Tx_vld(b_tx), .rd(b_rd), .rd_adr(b_adr), .load(b_load), .shift(b_shift),
      .busy(b_busy), .done(b_done), .err(b_err));

   // {Tx_vld, rd, load, shift, busy, done, err} expected in each state
   function automatic int exp_out(st_e st);
      case (st)
         ST_READ:  return 'b0100100;
         ST_LOAD:  return 'b0010100;
         ST_OFFER: return 'b1000100;
         ST_SHIFT: return 'b0001100;
         ST_NEXT:  return 'b0000100;
         ST_WAIT:  return 'b0000100;
         ST_DONE:  return 'b0000010;
         ST_ERR:   return 'b0000001;
         default:  return 0;
      endcase
   endfunction

   vec_t vecs[$];

   function automatic void add(int c, int s, int r, int f, st_e st, int a);
      vecs.push_back('{1'(c), 1'(s), 1'(r), 1'(f), st, 2'(a)});
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic big_reset();
      b_clr = 1'b0; b_start = 1'b0; b_rdy = 1'b0; b_fin = 1'b0;
      cyc();
      b_clr = 1'b1;
      cyc();
   endtask

   int n_rd, n_done, n_err, last_sh, txc, k_err, t_entry;
   int adr_seq[4];
   int sh[4];
   int tx_w[4];
   bit got, hit;

   initial begin
      // clr start rdy fin -> state after the edge, rd_adr
      add(0,0,0,0, ST_IDLE, 0);
      add(1,0,0,0, ST_IDLE, 0);
      add(1,1,0,0, ST_READ, 0);
      add(1,0,0,0, ST_LOAD, 0);
      add(1,0,1,0, ST_OFFER,0);
      add(1,0,1,0, ST_SHIFT,0);
      add(1,0,0,0, ST_SHIFT,0);
      add(1,0,0,0, ST_NEXT, 0);
      add(1,0,0,0, ST_READ, 1);
      add(1,0,0,0, ST_LOAD, 1);
      add(1,0,0,0, ST_OFFER,1);
      add(1,0,0,0, ST_OFFER,1);
      add(1,0,0,0, ST_OFFER,1);
      add(1,1,1,0, ST_SHIFT,1);
      add(1,1,0,0, ST_SHIFT,1);
      add(1,0,0,0, ST_NEXT, 1);
      add(1,0,0,0, ST_READ, 2);
      add(1,0,1,0, ST_LOAD, 2);
      add(1,0,1,0, ST_OFFER,2);
      add(1,0,1,0, ST_SHIFT,2);
      add(1,0,0,0, ST_SHIFT,2);
      add(1,0,0,0, ST_NEXT, 2);
      add(1,0,0,0, ST_READ, 3);
      add(1,0,1,0, ST_LOAD, 3);
      add(1,0,1,0, ST_OFFER,3);
      add(1,0,1,0, ST_SHIFT,3);
      add(1,0,0,0, ST_SHIFT,3);
      add(1,0,0,0, ST_NEXT, 3);
      add(1,0,0,0, ST_WAIT, 3);
      add(1,0,0,0, ST_WAIT, 3);
      add(1,1,0,1, ST_DONE, 3);
      add(1,1,0,0, ST_IDLE, 0);
      add(1,1,0,0, ST_READ, 0);
      add(0,1,0,0, ST_IDLE, 0);
      add(1,1,0,0, ST_READ, 0);
      add(1,0,0,0, ST_LOAD, 0);
      add(1,0,0,0, ST_OFFER,0);
      add(1,0,0,0, ST_OFFER,0);
      add(1,0,0,0, ST_OFFER,0);
      add(1,0,0,0, ST_ERR,  0);
      add(1,1,0,0, ST_ERR,  0);
      add(1,0,0,0, ST_IDLE, 0);

      #2;
      foreach (vecs[i]) begin
         s_clr = vecs[i].clr; s_start = vecs[i].start;
         s_rdy = vecs[i].rdy; s_fin = vecs[i].fin;
         cyc();
         chk($sformatf("vec%0d out", i), int'(s_obs), exp_out(vecs[i].st));
         chk($sformatf("vec%0d adr", i), int'(s_adr), int'(vecs[i].adr));
      end

      // full transfer, Rx_ready held, start toggled while shifting
      big_reset();
      chk("big reset", int'(b_obs), 0);
      b_start = 1'b1; b_rdy = 1'b1; b_fin = 1'b0;
      n_rd = 0; n_done = 0; last_sh = 0;
      for (int i = 0; i < 4; i++) begin adr_seq[i] = -1; sh[i] = 0; end
      for (int k = 1; k <= 52; k++) begin
         cyc();
         if (b_rd) begin
            if (n_rd < 4) adr_seq[n_rd] = int'(b_adr);
            n_rd++;
         end
         if (b_shift) begin
            if (n_rd >= 1 && n_rd <= 4) sh[n_rd-1]++;
            last_sh = k;
            b_start = ~b_start;
         end else begin
            b_start = 1'b1;
         end
         if (b_done) n_done++;
      end
      chk("A rd count", n_rd, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("A adr%0d", i), adr_seq[i], i);
         chk($sformatf("A shifts%0d", i), sh[i], 8);
      end
      chk("A last shift cycle", last_sh, 47);
      chk("A no early done", n_done, 0);
      chk("A wait_fin out", int'(b_obs), exp_out(ST_WAIT));
      b_fin = 1'b1;
      cyc();
      chk("A done out", int'(b_obs), exp_out(ST_DONE));
      chk("A done adr", int'(b_adr), 3);
      b_fin = 1'b0;
      cyc();
      chk("A idle out", int'(b_obs), 0);
      cyc();
      chk("A restart out", int'(b_obs), exp_out(ST_READ));
      chk("A restart adr", int'(b_adr), 0);

      // Rx_ready low for 5 OFFER cycles per word
      big_reset();
      b_start = 1'b1; b_rdy = 1'b0; b_fin = 1'b1;
      n_rd = 0; n_err = 0; txc = 0; got = 0;
      for (int i = 0; i < 4; i++) tx_w[i] = -1;
      for (int k = 0; k < 200 && !got; k++) begin
         cyc();
         b_start = 1'b0;
         if (b_rd) begin
            if (n_rd > 0 && n_rd <= 4) tx_w[n_rd-1] = txc;
            txc = 0;
            n_rd++;
         end
         if (b_tx) txc++;
         b_rdy = b_tx && (txc >= 6);
         if (b_err) n_err++;
         if (b_done) begin got = 1; tx_w[3] = txc; end
      end
      chk("B done seen", int'(got), 1);
      chk("B no err", n_err, 0);
      chk("B rd count", n_rd, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("B tx_vld%0d", i), tx_w[i], 6);

      // Rx_ready never rises
      big_reset();
      b_start = 1'b1; b_rdy = 1'b0; b_fin = 1'b0;
      k_err = -1; t_entry = -1;
      for (int k = 0; k < 400; k++) begin
         cyc();
         b_start = 1'b0;
         if (b_tx && t_entry < 0) t_entry = k;
         if (b_err) begin k_err = k; break; end
      end
      chk("C offer timeout", k_err - t_entry, 255);
      b_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("C err held%0d", i), int'(b_obs), exp_out(ST_ERR));
      end
      b_start = 1'b0;
      cyc();
      chk("C back to idle", int'(b_obs), 0);

      // Rx_finish withheld
      big_reset();
      b_start = 1'b1; b_rdy = 1'b1; b_fin = 1'b0;
      k_err = -1; n_done = 0;
      for (int k = 1; k <= 400; k++) begin
         cyc();
         b_start = 1'b0;
         if (b_done) n_done++;
         if (b_err) begin k_err = k; break; end
      end
      chk("D wait_fin timeout", k_err, 304);
      chk("D no done", n_done, 0);
      cyc();
      chk("D back to idle", int'(b_obs), 0);

      // reset during SHIFT of word 2
      big_reset();
      b_start = 1'b1; b_rdy = 1'b1; b_fin = 1'b0;
      hit = 0;
      for (int k = 0; k < 100; k++) begin
         cyc();
         b_start = 1'b0;
         if (b_shift && b_adr == 2'd2) begin hit = 1; break; end
      end
      chk("E reached word2", int'(hit), 1);
      b_clr = 1'b0;
      cyc();
      chk("E reset out", int'(b_obs), 0);
      chk("E reset adr", int'(b_adr), 0);
      b_clr = 1'b1;
      cyc();
      chk("E release out", int'(b_obs), 0);
      b_start = 1'b1;
      cyc();
      chk("E restart out", int'(b_obs), exp_out(ST_READ));
      chk("E restart adr", int'(b_adr), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
